coin_acceptor: RTL
==================

Name: coin_acceptor

Overview:
Front-end stage for the vending controller. It turns the two raw, asynchronous, bouncy coin-sensor lines (nickel, dime) into clean single-cycle coin codes on the same 2-bit encoding the vending FSM consumes: 00 none, 01 nickel, 10 dime. The stage synchronises and debounces each sensor and rejects simultaneous insertions. A lockout blocks double-counting of one physical coin. Output `coin` connects directly to the vending FSM `coin` input.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required to change a debounced level; legal range 1..2^CNT_W-1.
- LOCKOUT_CYCLES, 8: cycles the acceptor ignores new edges after emitting a coin or reject; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the debounce and lockout counters.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: reset; synchronous, active-high.
- nickel_raw, input, 1: raw nickel sensor; asynchronous, may bounce.
- dime_raw, input, 1: raw dime sensor; asynchronous, may bounce.
- coin, output, 2: registered one-cycle coin code. 01 = nickel, 10 = dime, 00 otherwise; 11 is never driven.
- reject, output, 1: registered one-cycle pulse when an insertion is refused because both sensors are active.
- busy, output, 1: registered; high in LOCKOUT and WAIT_RELEASE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Synchroniser flops, debounced levels, previous-level registers and counters all go to 0.
  - FSM goes to IDLE.
  - coin=00, reject=0, busy=0 from the next cycle.
  - Reset mid-operation abandons any lockout or pending debounce.
  - A sensor held high across reset release is treated as a new insertion once it debounces.
- Synchroniser: two flops per sensor (s1, s2).
- Debounce, per sensor, with level `deb` and counter `cnt`, each edge:
  - If s2 == deb: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: deb <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any s2 run shorter than DEBOUNCE_CYCLES is filtered out.
- Edge detect: `deb_prev` registers `deb` every cycle in all states; rise = deb & ~deb_prev.
- Latency: counting the edge that first samples raw=1 as edge 1, deb rises at edge DEBOUNCE_CYCLES+2 and coin is driven at edge DEBOUNCE_CYCLES+3. With defaults that is edge 7, held for exactly one cycle.
- FSM states:
  - IDLE:
    - Nickel rise with dime deb=0 -> coin<=01, go to LOCKOUT.
    - Dime rise with nickel deb=0 -> coin<=10, go to LOCKOUT.
    - Both rise in the same cycle, or one rises while the other deb=1 -> reject<=1, coin stays 00, go to LOCKOUT.
    - Otherwise stay in IDLE.
  - LOCKOUT:
    - A lockout counter is loaded to 0 on entry and increments each cycle.
    - After LOCKOUT_CYCLES cycles in this state, go to WAIT_RELEASE.
    - All rises are ignored (no pulse).
  - WAIT_RELEASE: stay until both deb levels are 0, then go to IDLE. Rises are ignored.
- coin and reject are 00/0 in every cycle except the single pulse cycle; they are never asserted together.
- busy goes high the same cycle the coin/reject pulse is driven and drops the cycle IDLE is re-entered.
- A coin held through lockout produces no second pulse, because its rise was already consumed while the FSM was in LOCKOUT.

Test Plan:
- Clean nickel (defaults): after reset, nickel_raw=1 for 20 cycles then 0 -> coin=01 for exactly one cycle at edge 7; busy high from edge 7 until both deb=0 and lockout has expired; no other pulse.
- Bounce filtering: dime_raw toggles 1,0,1,0 each cycle for 6 cycles, then holds 1 for 10 cycles -> exactly one coin=10 pulse, DEBOUNCE_CYCLES+3 edges after the stable-1 segment starts; the 3-cycle glitch alone (separate run) -> no pulse.
- Simultaneous coins: nickel_raw and dime_raw rise on the same edge and hold for 12 cycles -> reject=1 for one cycle at edge 7, coin stays 00, busy asserts.
- Lockout/release: nickel_raw held high 40 cycles -> one coin=01; FSM remains in WAIT_RELEASE until nickel deb falls; a dime inserted during LOCKOUT produces nothing; a dime inserted after return to IDLE -> coin=10.
- Reset mid-lockout: rst=1 for one cycle three cycles after a coin pulse -> busy=0, coin=00 next cycle; a fresh nickel then yields coin=01 with full DEBOUNCE_CYCLES+3 latency.
- Back-to-back with vending FSM: dime, dime, spaced 30 cycles apart, fed through to the vending FSM -> exactly two coin=10 pulses and the downstream dispense asserts once.

Source files
------------

// File: rtl/coin_acceptor.sv
// Coin sensor front end: sync + debounce nickel/dime, emit one-cycle coin/reject, lock out repeats.
// Latency: coin/reject registered DEBOUNCE_CYCLES+3 edges after raw rises; no backpressure, pulses are fire-and-forget.
module coin_acceptor #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LOCKOUT_CYCLES  = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       nickel_raw,
    input  logic       dime_raw,
    output logic [1:0] coin,
    output logic       reject,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    // Bit 0 is the nickel sensor, bit 1 the dime sensor.
    logic [1:0]            s1_q, s2_q;
    logic [1:0]            deb_q, deb_d;
    logic [1:0]            deb_prev_q;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            rise;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      lock_q, lock_d;
    logic [1:0]            coin_q, coin_d;
    logic                  reject_q, reject_d;
    logic                  busy_q, busy_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;

    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        coin_d   = 2'b00;
        reject_d = 1'b0;
        case (state_q)
            IDLE: begin
                lock_d = '0;
                if (rise != 2'b00) begin
                    // A rise with the other level also high is a double insertion;
                    // otherwise deb_q holds exactly the one-hot coin code.
                    if (deb_q == 2'b11) begin
                        reject_d = 1'b1;
                    end else begin
                        coin_d = deb_q;
                    end
                    state_d = LOCKOUT;
                end
            end
            LOCKOUT: begin
                if (lock_q == LOCK_MAX) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    lock_d = lock_q + CNT_W'(1);
                end
            end
            WAIT_RELEASE: begin
                if (deb_q == 2'b00) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= '0;
            s2_q       <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            state_q    <= IDLE;
            lock_q     <= '0;
            coin_q     <= 2'b00;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            s1_q       <= {dime_raw, nickel_raw};
            s2_q       <= s1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            lock_q     <= lock_d;
            coin_q     <= coin_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
        end
    end

    assign coin   = coin_q;
    assign reject = reject_q;
    assign busy   = busy_q;

endmodule
